red_pitaya_ad5689_rx: RTL and testbench

- Synthesizable responder for the AD5689 dual 16-bit DAC SPI interface; models the device end of the link driven by the slow-DAC SPI master.
- Oversamples SCLK/SDIN/SYNCn/LDACn/RSTn on the 125 MHz system clock and decodes 24-bit frames.
- Maintains input and DAC registers for channels A and B, plus frame and error statistics readable over the system bus.
- Used for on-chip loopback checking of the slow-DAC path and as the device model in simulation.

---
 rtl/red_pitaya_ad5689_rx.sv | 206 ++++++++++++++++++++
 tb/tb_red_pitaya_ad5689_rx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_ad5689_rx.sv
// AD5689 SPI device responder: oversamples the slow-DAC SPI pins, decodes 24-bit frames into
// input/DAC registers for channels A/B and exposes them plus frame statistics on the system bus.
module red_pitaya_ad5689_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 24
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        spi_sclk,
    input  logic        spi_sdin,
    input  logic        spi_syncn,
    input  logic        spi_ldacn,
    input  logic        spi_rstn,
    output logic [15:0] dac_a_o,
    output logic [15:0] dac_b_o,
    output logic        dac_upd_o,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic [3:0]  sys_sel,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_err,
    output logic        sys_ack
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_EVAL} state_t;
    localparam logic [4:0] LP_FRAME_BITS = 5'(FRAME_BITS);

    // pin bundle order: {rstn, ldacn, syncn, sdin, sclk}
    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic [4:0]  r_dly;
    logic [4:0]  w_s;
    logic        w_sclk_fall, w_syncn_fall, w_syncn_rise, w_ldac_fall;

    state_t      r_state;
    logic [23:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_in_a, r_in_b, r_dac_a, r_dac_b;
    logic [15:0] r_frame_cnt, r_err_cnt;
    logic [23:0] r_last;
    logic        r_upd, r_ack;
    logic [31:0] r_rdata;

    logic [3:0]  w_cmd, w_addr;
    logic        w_sel_a, w_sel_b;
    logic [15:0] w_in_a, w_in_b, w_dac_a, w_dac_b;
    logic        w_upd, w_frame_inc, w_err_inc, w_cnt_clr;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_s          = r_sync[SYNC_STAGES-1];
    assign w_sclk_fall  = r_dly[0] & ~w_s[0];
    assign w_syncn_fall = r_dly[2] & ~w_s[2];
    assign w_syncn_rise = ~r_dly[2] & w_s[2];
    assign w_ldac_fall  = r_dly[3] & ~w_s[3];

    assign w_cmd   = r_shift[23:20];
    assign w_addr  = r_shift[19:16];
    assign w_sel_a = (w_addr == 4'b0001) || (w_addr == 4'b1001);
    assign w_sel_b = (w_addr == 4'b1000) || (w_addr == 4'b1001);

    assign w_cnt_clr = sys_wen && (sys_addr[19:0] == 20'h10);
    assign w_unused  = &{1'b0, sys_sel, sys_wdata, sys_addr[31:20]};

    // Frame decode, then LDAC transfer so a coinciding edge sees the post-write inputs.
    always_comb begin
        w_in_a      = r_in_a;
        w_in_b      = r_in_b;
        w_dac_a     = r_dac_a;
        w_dac_b     = r_dac_b;
        w_upd       = 1'b0;
        w_frame_inc = 1'b0;
        w_err_inc   = 1'b0;
        if (!w_s[4]) begin
            w_in_a  = '0;
            w_in_b  = '0;
            w_dac_a = '0;
            w_dac_b = '0;
        end else begin
            if (r_state == ST_EVAL) begin
                if (r_bit_cnt != LP_FRAME_BITS) begin
                    w_err_inc = 1'b1;
                end else begin
                    case (w_cmd)
                        4'b0000: w_frame_inc = 1'b1;
                        4'b0001, 4'b0010, 4'b0011: begin
                            if (!(w_sel_a || w_sel_b)) begin
                                w_err_inc = 1'b1;
                            end else begin
                                w_frame_inc = 1'b1;
                                if (w_cmd != 4'b0010) begin
                                    if (w_sel_a) w_in_a = r_shift[15:0];
                                    if (w_sel_b) w_in_b = r_shift[15:0];
                                end
                                if (w_cmd == 4'b0011 || (w_cmd == 4'b0001 && !w_s[3])) begin
                                    if (w_sel_a) w_dac_a = r_shift[15:0];
                                    if (w_sel_b) w_dac_b = r_shift[15:0];
                                    w_upd = 1'b1;
                                end else if (w_cmd == 4'b0010) begin
                                    if (w_sel_a) w_dac_a = r_in_a;
                                    if (w_sel_b) w_dac_b = r_in_b;
                                    w_upd = 1'b1;
                                end
                            end
                        end
                        4'b0110: begin
                            w_frame_inc = 1'b1;
                            w_in_a      = '0;
                            w_in_b      = '0;
                            w_dac_a     = '0;
                            w_dac_b     = '0;
                            w_upd       = 1'b1;
                        end
                        default: w_err_inc = 1'b1;
                    endcase
                end
            end
            if (w_ldac_fall) begin
                w_dac_a = w_in_a;
                w_dac_b = w_in_b;
                w_upd   = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (sys_addr[19:0])
            20'h00:  w_rdata = {16'h0, r_dac_a};
            20'h04:  w_rdata = {16'h0, r_dac_b};
            20'h08:  w_rdata = {16'h0, r_in_a};
            20'h0C:  w_rdata = {16'h0, r_in_b};
            20'h10:  w_rdata = {r_err_cnt, r_frame_cnt};
            20'h14:  w_rdata = {8'h0, r_last};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync      <= '0;
            r_dly       <= '0;
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_in_a      <= '0;
            r_in_b      <= '0;
            r_dac_a     <= '0;
            r_dac_b     <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_last      <= '0;
            r_upd       <= 1'b0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], {spi_rstn, spi_ldacn, spi_syncn, spi_sdin, spi_sclk}};
            r_dly   <= w_s;
            r_in_a  <= w_in_a;
            r_in_b  <= w_in_b;
            r_dac_a <= w_dac_a;
            r_dac_b <= w_dac_b;
            r_upd   <= w_upd;
            r_ack   <= sys_wen | sys_ren;
            r_rdata <= sys_ren ? w_rdata : '0;
            if (w_frame_inc) r_last <= r_shift;

            if (!w_s[4]) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_syncn_fall) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                    ST_SHIFT: begin
                        if (w_sclk_fall) begin
                            r_shift   <= {r_shift[22:0], w_s[1]};
                            r_bit_cnt <= (r_bit_cnt == 5'd31) ? 5'd31 : r_bit_cnt + 5'd1;
                        end
                        if (w_syncn_rise) r_state <= ST_EVAL;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // a bus clear wins over an increment in the same cycle
            if (w_cnt_clr) begin
                r_frame_cnt <= '0;
                r_err_cnt   <= '0;
            end else begin
                if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
                if (w_err_inc)   r_err_cnt   <= r_err_cnt + 16'd1;
            end
        end
    end

    assign dac_a_o   = r_dac_a;
    assign dac_b_o   = r_dac_b;
    assign dac_upd_o = r_upd;
    assign sys_rdata = r_rdata;
    assign sys_ack   = r_ack;
    assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_ad5689_rx.sv
// Bench for red_pitaya_ad5689_rx: directed test-plan frames with literal expectations, then
// randomized frames/LDAC/reset/bus traffic checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_red_pitaya_ad5689_rx;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        spi_sclk, spi_sdin, spi_syncn, spi_ldacn, spi_rstn;
    logic [15:0] dac_a_o, dac_b_o;
    logic        dac_upd_o;
    logic [31:0] sys_addr, sys_wdata, sys_rdata;
    logic [3:0]  sys_sel;
    logic        sys_wen, sys_ren, sys_err, sys_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    bit chk_on   = 1'b0;

    red_pitaya_ad5689_rx #(.SYNC_STAGES(S), .FRAME_BITS(24)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .spi_sclk(spi_sclk), .spi_sdin(spi_sdin), .spi_syncn(spi_syncn),
        .spi_ldacn(spi_ldacn), .spi_rstn(spi_rstn),
        .dac_a_o(dac_a_o), .dac_b_o(dac_b_o), .dac_upd_o(dac_upd_o),
        .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
        .sys_err(sys_err), .sys_ack(sys_ack)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_in_a, m_in_b, m_dac_a, m_dac_b, m_fcnt, m_ecnt;
    logic [23:0] m_last;
    logic        m_upd, m_ack;
    logic [31:0] m_rdata;
    logic [4:0]  m_hist [0:S];   // m_hist[k] = pins seen k+1 clock edges ago
    bit          m_collect, m_pending;
    bit          m_bits[$];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[19:0])
            20'h00:  return {16'h0, m_dac_a};
            20'h04:  return {16'h0, m_dac_b};
            20'h08:  return {16'h0, m_in_a};
            20'h0C:  return {16'h0, m_in_b};
            20'h10:  return {m_ecnt, m_fcnt};
            20'h14:  return {8'h0, m_last};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_eval(input logic ldacn_lvl);
        logic [23:0] v;
        int cmd, adr;
        bit a, b;
        if (m_bits.size() != 24) begin
            m_ecnt++;
            return;
        end
        v = '0;
        foreach (m_bits[i]) v = v * 2 + 24'(m_bits[i]);
        cmd = int'(v[23:20]);
        adr = int'(v[19:16]);
        a = (adr == 1) || (adr == 9);
        b = (adr == 8) || (adr == 9);
        if (cmd == 0) begin
            m_fcnt++; m_last = v;
        end else if (cmd == 6) begin
            m_fcnt++; m_last = v;
            m_in_a = 0; m_in_b = 0; m_dac_a = 0; m_dac_b = 0; m_upd = 1;
        end else if (cmd >= 1 && cmd <= 3 && (a || b)) begin
            m_fcnt++; m_last = v;
            if (cmd == 2) begin
                if (a) m_dac_a = m_in_a;
                if (b) m_dac_b = m_in_b;
                m_upd = 1;
            end else begin
                if (a) m_in_a = v[15:0];
                if (b) m_in_b = v[15:0];
                if (cmd == 3 || !ldacn_lvl) begin
                    if (a) m_dac_a = v[15:0];
                    if (b) m_dac_b = v[15:0];
                    m_upd = 1;
                end
            end
        end else begin
            m_ecnt++;
        end
    endtask

    always @(posedge clk) begin
        logic [4:0] sy, dl;
        if (!rstn_i) begin
            m_in_a = 0; m_in_b = 0; m_dac_a = 0; m_dac_b = 0;
            m_fcnt = 0; m_ecnt = 0; m_last = 0;
            m_upd = 0; m_ack = 0; m_rdata = 0;
            m_collect = 0; m_pending = 0; m_bits.delete();
            for (int k = 0; k <= S; k++) m_hist[k] = '0;
        end else begin
            sy = m_hist[S-1];
            dl = m_hist[S];
            m_upd   = 0;
            m_ack   = sys_wen | sys_ren;
            m_rdata = sys_ren ? m_read(sys_addr) : 32'h0;
            if (!sy[4]) begin
                m_in_a = 0; m_in_b = 0; m_dac_a = 0; m_dac_b = 0;
                m_collect = 0; m_pending = 0;
            end else begin
                if (m_pending) begin
                    m_pending = 0;
                    m_eval(sy[3]);
                end else if (m_collect) begin
                    if (dl[0] && !sy[0]) m_bits.push_back(sy[1]);
                    if (!dl[2] && sy[2]) begin m_collect = 0; m_pending = 1; end
                end else if (dl[2] && !sy[2]) begin
                    m_collect = 1;
                    m_bits.delete();
                end
                if (dl[3] && !sy[3]) begin
                    m_dac_a = m_in_a; m_dac_b = m_in_b; m_upd = 1;
                end
            end
            if (sys_wen && sys_addr[19:0] == 20'h10) begin m_fcnt = 0; m_ecnt = 0; end
            for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = {spi_rstn, spi_ldacn, spi_syncn, spi_sdin, spi_sclk};
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dac_a", {16'h0, dac_a_o}, {16'h0, m_dac_a});
            chk("dac_b", {16'h0, dac_b_o}, {16'h0, m_dac_b});
            chk("dac_upd", {31'h0, dac_upd_o}, {31'h0, m_upd});
            chk("sys_ack", {31'h0, sys_ack}, {31'h0, m_ack});
            chk("sys_rdata", sys_rdata, m_rdata);
            chk("sys_err", {31'h0, sys_err}, 32'h0);
            if (dac_upd_o === 1'b1) upd_cnt++;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_frame(input logic [31:0] w, input int nbits, input int half,
                              input int abort_at, input int ldac_dly);
        spi_syncn = 1'b0;
        #(half);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_sdin = w[i];
            #(half);
            spi_sclk = 1'b0;
            if (i == abort_at) spi_rstn = 1'b0;
            #(half);
            spi_sclk = 1'b1;
        end
        #(half);
        spi_syncn = 1'b1;
        #16;
        spi_rstn = 1'b1;
        if (ldac_dly >= 0) begin
            #(8 * ldac_dly);
            spi_ldacn = 1'b0;
            #40;
            spi_ldacn = 1'b1;
        end
        #96;
    endtask

    task automatic frame24(input logic [31:0] w);
        send_frame(w, 24, 16, -1, -1);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_ren = 1'b1;
        @(negedge clk);
        sys_ren = 1'b0;
        chk("read_ack", {31'h0, sys_ack}, 32'h1);
        d = sys_rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
        chk("write_ack", {31'h0, sys_ack}, 32'h1);
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(name, d, exp);
    endtask

    initial begin
        logic [31:0] bus_addrs [8];
        logic [31:0] w, d;
        int cmd, adr, nb, half, ab, ld;
        bit hold;
        bus_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h40010};

        rstn_i = 1'b0;
        spi_sclk = 1'b1; spi_sdin = 1'b0; spi_syncn = 1'b0; spi_ldacn = 1'b1; spi_rstn = 1'b1;
        sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;
        repeat (4) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_dac_a", {16'h0, dac_a_o}, 32'h0);
        chk("rst_dac_b", {16'h0, dac_b_o}, 32'h0);
        chk("rst_upd", {31'h0, dac_upd_o}, 32'h0);
        chk("rst_ack", {31'h0, sys_ack}, 32'h0);
        chk("rst_rdata", sys_rdata, 32'h0);
        rstn_i = 1'b1;

        // syncn already low at reset release: clocked bits must not be captured
        repeat (3) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            spi_sdin = 1'b1; #16; spi_sclk = 1'b0; #16; spi_sclk = 1'b1;
        end
        #16; spi_syncn = 1'b1; #96;
        read_chk("nocap_cnt", 32'h10, 32'h0);
        read_chk("nocap_last", 32'h14, 32'h0);

        frame24(32'h31ABCD);
        chk("f1_dac_a", {16'h0, dac_a_o}, 32'hABCD);
        chk("f1_dac_b", {16'h0, dac_b_o}, 32'h0);
        chk("f1_upd_once", upd_cnt, 1);
        read_chk("f1_cnt", 32'h10, 32'h0000_0001);
        read_chk("f1_last", 32'h14, 32'h0031_ABCD);

        frame24(32'h181234);
        read_chk("f2_in_b", 32'hC, 32'h1234);
        chk("f2_dac_b_pre", {16'h0, dac_b_o}, 32'h0);
        spi_ldacn = 1'b0; #40; spi_ldacn = 1'b1; #40;
        chk("f2_dac_b_post", {16'h0, dac_b_o}, 32'h1234);
        chk("f2_dac_a_post", {16'h0, dac_a_o}, 32'hABCD);

        frame24(32'h391111);
        spi_ldacn = 1'b0; #40;
        frame24(32'h110000);
        spi_ldacn = 1'b1; #40;
        chk("tr_dac_a", {16'h0, dac_a_o}, 32'h0);
        chk("tr_dac_b", {16'h0, dac_b_o}, 32'h1111);

        bus_write(32'h10, 32'h0);
        read_chk("clr_cnt", 32'h10, 32'h0);
        frame24(32'h000000);
        frame24(32'h31ABCD);
        send_frame(32'h8FFFF, 20, 16, -1, -1);
        chk("short_dac_a", {16'h0, dac_a_o}, 32'hABCD);
        frame24(32'h181234);
        read_chk("cnt_3_1", 32'h10, 32'h0001_0003);
        send_frame(32'h1_31_5555, 25, 16, -1, -1);
        read_chk("cnt_long", 32'h10, 32'h0002_0003);
        chk("long_dac_a", {16'h0, dac_a_o}, 32'hABCD);

        frame24(32'h600000);
        chk("swr_dac_a", {16'h0, dac_a_o}, 32'h0);
        chk("swr_dac_b", {16'h0, dac_b_o}, 32'h0);
        read_chk("swr_in_b", 32'hC, 32'h0);
        frame24(32'h391111);
        send_frame(32'h315555, 24, 16, 10, -1);
        chk("abort_dac_a", {16'h0, dac_a_o}, 32'h0);
        read_chk("abort_in_a", 32'h8, 32'h0);
        read_chk("abort_cnt", 32'h10, 32'h0002_0005);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: cmd = 0;  1: cmd = 1;  2: cmd = 2;  3: cmd = 3;  4: cmd = 6;
                default: cmd = $urandom_range(0, 15);
            endcase
            case ($urandom_range(0, 3))
                0: adr = 1;  1: adr = 8;  2: adr = 9;
                default: adr = $urandom_range(0, 15);
            endcase
            w = {$urandom_range(0, 255), 4'(cmd), 4'(adr), 16'($urandom)};
            nb   = ($urandom_range(0, 9) < 8) ? 24 : $urandom_range(18, 30);
            half = 8 * $urandom_range(2, 4);
            ab   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, nb - 1) : -1;
            hold = ($urandom_range(0, 3) == 0);
            ld   = (!hold && $urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            if (hold) begin spi_ldacn = 1'b0; #16; end
            send_frame(w, nb, half, ab, ld);
            if (hold) begin spi_ldacn = 1'b1; #16; end
            if ($urandom_range(0, 1) == 1) bus_read(bus_addrs[$urandom_range(0, 7)], d);
            else if ($urandom_range(0, 19) == 0) bus_write(32'h10, 32'h0);
        end
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
